// File: rtl/ctl_defs.sv
// Shared sequencer definitions: opcode values, FSM state encoding and the strobe
// vector bit positions used by both the datapath and the bench.
package ctl_defs;

  localparam logic [2:0] OPC_HLT = 3'd0;
  localparam logic [2:0] OPC_SKZ = 3'd1;
  localparam logic [2:0] OPC_ADD = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_LDA = 3'd5;
  localparam logic [2:0] OPC_STO = 3'd6;
  localparam logic [2:0] OPC_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_OPRD   = 4'd3,
    ST_ACC    = 4'd4,
    ST_STORE  = 4'd5,
    ST_STHOLD = 4'd6,
    ST_JUMP   = 4'd7,
    ST_SKIP   = 4'd8,
    ST_HALT   = 4'd9
  } state_e;

  localparam int STB_INC_PC       = 0;
  localparam int STB_LOAD_ACC     = 1;
  localparam int STB_LOAD_PC      = 2;
  localparam int STB_RD           = 3;
  localparam int STB_WR           = 4;
  localparam int STB_LOAD_IR      = 5;
  localparam int STB_HALT         = 6;
  localparam int STB_DATA_CTL_ENA = 7;
  localparam int STB_N            = 8;

endpackage

// File: rtl/ctl_wait_timer.sv
// Memory wait-state watchdog: counts consecutive mem_rdy-low cycles of one transfer.
// timeout is combinational on the held count, so a late mem_rdy still rescues the beat.
module ctl_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_mem_rdy,
  output logic o_timeout
);

  localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || i_mem_rdy) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = !i_clear && !i_mem_rdy && (r_cnt == CNT_MAX);

endmodule

// File: rtl/ctl_sequencer.sv
// Instruction-control sequencer: multi-beat fetch, decode, execute with mem_rdy wait states,
// bus timeout to HALT and go/run resume. Strobes decode from registered state (inc_pc in FETCH is Mealy).
module ctl_sequencer
  import ctl_defs::*;
#(
  parameter  int OPC_W       = 3,
  parameter  int FETCH_BEATS = 2,
  parameter  int WAIT_MAX    = 15,
  localparam int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_go,
  input  logic              i_zero,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic              i_mem_rdy,
  output logic              o_inc_pc,
  output logic              o_load_acc,
  output logic              o_load_pc,
  output logic              o_rd,
  output logic              o_wr,
  output logic              o_load_ir,
  output logic              o_halt,
  output logic              o_data_ctl_ena,
  output logic [BEAT_W-1:0] o_ir_beat,
  output logic              o_illegal,
  output logic              o_bus_err,
  output logic              o_busy
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FETCH_BEATS - 1);

  state_e            r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_illegal;
  logic              r_bus_err;

  state_e            w_next;
  logic              w_timeout;
  logic              w_tmr_clear;
  logic              w_opc_upper_nz;
  logic [2:0]        w_opc_low;
  logic [STB_N-1:0]  w_stb;
  logic [BEAT_W-1:0] w_ir_beat;

  assign w_next         = i_run ? ST_FETCH : ST_IDLE;
  assign w_opc_upper_nz = (i_opcode >> 3) != '0;
  assign w_opc_low      = i_opcode[2:0];
  assign w_tmr_clear    = !(r_state inside {ST_FETCH, ST_OPRD, ST_STORE});

  ctl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_tmr_clear),
    .i_mem_rdy (i_mem_rdy),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_run) r_state <= ST_FETCH;
        ST_FETCH: begin
          if (i_mem_rdy) begin
            if (r_beat_cnt == BEAT_LAST) begin
              r_beat_cnt <= '0;
              r_state    <= ST_DECODE;
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
          end else if (w_timeout) begin
            r_beat_cnt <= '0;
            r_bus_err  <= 1'b1;
            r_state    <= ST_HALT;
          end
        end
        ST_DECODE: begin
          if (w_opc_upper_nz) begin
            r_illegal <= 1'b1;
            r_state   <= w_next;
          end else begin
            case (w_opc_low)
              OPC_HLT:                            r_state <= ST_HALT;
              OPC_SKZ:                            r_state <= i_zero ? ST_SKIP : w_next;
              OPC_ADD, OPC_AND, OPC_XOR, OPC_LDA: r_state <= ST_OPRD;
              OPC_STO:                            r_state <= ST_STORE;
              default:                            r_state <= ST_JUMP;
            endcase
          end
        end
        ST_OPRD: begin
          if (i_mem_rdy) begin
            r_state <= ST_ACC;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_HALT;
          end
        end
        ST_STORE: begin
          if (i_mem_rdy) begin
            r_state <= ST_STHOLD;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_HALT;
          end
        end
        ST_ACC, ST_STHOLD, ST_JUMP: r_state <= w_next;
        // Skip reuses the beat counter to step the PC past one whole instruction.
        ST_SKIP: begin
          if (r_beat_cnt == BEAT_LAST) begin
            r_beat_cnt <= '0;
            r_state    <= w_next;
          end else begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end
        end
        ST_HALT: begin
          if (i_go) begin
            r_state <= ST_FETCH;
          end else if (!i_run) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_stb     = '0;
    w_ir_beat = '0;
    case (r_state)
      ST_FETCH: begin
        w_stb[STB_RD]      = 1'b1;
        w_stb[STB_LOAD_IR] = 1'b1;
        w_stb[STB_INC_PC]  = i_mem_rdy;
        w_ir_beat          = r_beat_cnt;
      end
      ST_OPRD: w_stb[STB_RD] = 1'b1;
      ST_ACC: begin
        w_stb[STB_RD]       = 1'b1;
        w_stb[STB_LOAD_ACC] = 1'b1;
      end
      ST_STORE: begin
        w_stb[STB_WR]           = 1'b1;
        w_stb[STB_DATA_CTL_ENA] = 1'b1;
      end
      ST_STHOLD: w_stb[STB_DATA_CTL_ENA] = 1'b1;
      ST_JUMP:   w_stb[STB_LOAD_PC]      = 1'b1;
      ST_SKIP:   w_stb[STB_INC_PC]       = 1'b1;
      ST_HALT:   w_stb[STB_HALT]         = 1'b1;
      default: ;
    endcase
  end

  assign o_inc_pc       = w_stb[STB_INC_PC];
  assign o_load_acc     = w_stb[STB_LOAD_ACC];
  assign o_load_pc      = w_stb[STB_LOAD_PC];
  assign o_rd           = w_stb[STB_RD];
  assign o_wr           = w_stb[STB_WR];
  assign o_load_ir      = w_stb[STB_LOAD_IR];
  assign o_halt         = w_stb[STB_HALT];
  assign o_data_ctl_ena = w_stb[STB_DATA_CTL_ENA];
  assign o_ir_beat      = w_ir_beat;
  assign o_illegal      = r_illegal;
  assign o_bus_err      = r_bus_err;
  assign o_busy         = !(r_state inside {ST_IDLE, ST_HALT});

endmodule

// File: tb/tb_ctl_sequencer.sv
// Bench for ctl_sequencer: table and hand-written sequences on two parameter sets,
// then randomized stimulus against an instruction-level step-queue model.
module tb_ctl_sequencer;
  import ctl_defs::*;

  localparam logic [7:0] B_INC  = 8'(1) << STB_INC_PC;
  localparam logic [7:0] B_ACC  = 8'(1) << STB_LOAD_ACC;
  localparam logic [7:0] B_LPC  = 8'(1) << STB_LOAD_PC;
  localparam logic [7:0] B_RD   = 8'(1) << STB_RD;
  localparam logic [7:0] B_WR   = 8'(1) << STB_WR;
  localparam logic [7:0] B_IR   = 8'(1) << STB_LOAD_IR;
  localparam logic [7:0] B_HALT = 8'(1) << STB_HALT;
  localparam logic [7:0] B_DEN  = 8'(1) << STB_DATA_CTL_ENA;
  localparam logic [7:0] B_FI   = B_RD | B_IR | B_INC;
  localparam logic [7:0] B_F    = B_RD | B_IR;

  typedef struct packed {
    logic [7:0] stb;
    logic [1:0] beat;
    logic       ill;
    logic       berr;
    logic       busy;
  } obs_t;

  typedef struct {
    bit         run;
    bit         rdy;
    logic [3:0] opc;
    logic [7:0] stb;
    int         beat;
    bit         busy;
  } vec_t;

  typedef struct {
    int kind;
    int beat;
  } step_t;

  localparam int K_FETCH = 0, K_DEC = 1, K_RD = 2, K_ACC = 3, K_WR = 4, K_HOLD = 5, K_JMP = 6, K_SKIP = 7;
  localparam int M_IDLE = 0, M_HALT = 1, M_ACT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, go = 1'b0, zero = 1'b0, mem_rdy = 1'b0;
  logic [3:0] opcode = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  // default-parameter instance
  logic d_inc, d_acc, d_lpc, d_rd, d_wr, d_ir, d_halt, d_den, d_ill, d_berr, d_busy;
  logic [0:0] d_beat;
  // OPC_W=4, FETCH_BEATS=3, WAIT_MAX=4 instance
  logic a_inc, a_acc, a_lpc, a_rd, a_wr, a_ir, a_halt, a_den, a_ill, a_berr, a_busy;
  logic [1:0] a_beat;

  always #5 clk = ~clk;

  ctl_sequencer u_dflt (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_go(go), .i_zero(zero),
    .i_opcode(opcode[2:0]), .i_mem_rdy(mem_rdy),
    .o_inc_pc(d_inc), .o_load_acc(d_acc), .o_load_pc(d_lpc), .o_rd(d_rd), .o_wr(d_wr),
    .o_load_ir(d_ir), .o_halt(d_halt), .o_data_ctl_ena(d_den), .o_ir_beat(d_beat),
    .o_illegal(d_ill), .o_bus_err(d_berr), .o_busy(d_busy)
  );

  ctl_sequencer #(.OPC_W(4), .FETCH_BEATS(3), .WAIT_MAX(4)) u_alt (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_go(go), .i_zero(zero),
    .i_opcode(opcode), .i_mem_rdy(mem_rdy),
    .o_inc_pc(a_inc), .o_load_acc(a_acc), .o_load_pc(a_lpc), .o_rd(a_rd), .o_wr(a_wr),
    .o_load_ir(a_ir), .o_halt(a_halt), .o_data_ctl_ena(a_den), .o_ir_beat(a_beat),
    .o_illegal(a_ill), .o_bus_err(a_berr), .o_busy(a_busy)
  );

  function automatic obs_t get_obs();
    obs_t o;
    o = '0;
    if (sel == 0) begin
      o.stb[STB_INC_PC] = d_inc;  o.stb[STB_LOAD_ACC] = d_acc; o.stb[STB_LOAD_PC] = d_lpc;
      o.stb[STB_RD]     = d_rd;   o.stb[STB_WR]       = d_wr;  o.stb[STB_LOAD_IR] = d_ir;
      o.stb[STB_HALT]   = d_halt; o.stb[STB_DATA_CTL_ENA] = d_den;
      o.beat = {1'b0, d_beat}; o.ill = d_ill; o.berr = d_berr; o.busy = d_busy;
    end else begin
      o.stb[STB_INC_PC] = a_inc;  o.stb[STB_LOAD_ACC] = a_acc; o.stb[STB_LOAD_PC] = a_lpc;
      o.stb[STB_RD]     = a_rd;   o.stb[STB_WR]       = a_wr;  o.stb[STB_LOAD_IR] = a_ir;
      o.stb[STB_HALT]   = a_halt; o.stb[STB_DATA_CTL_ENA] = a_den;
      o.beat = a_beat; o.ill = a_ill; o.berr = a_berr; o.busy = a_busy;
    end
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @%0t dut%0d: got stb=%b beat=%0d ill=%b berr=%b busy=%b, want stb=%b beat=%0d ill=%b berr=%b busy=%b",
                 nm, $time, sel, act.stb, act.beat, act.ill, act.berr, act.busy,
                 exp.stb, exp.beat, exp.ill, exp.berr, exp.busy);
    end
  endtask

  function automatic obs_t mk(input logic [7:0] stb, input int beat, input bit busy,
                              input bit ill, input bit berr);
    obs_t e;
    e.stb = stb; e.beat = 2'(beat); e.busy = busy; e.ill = ill; e.berr = berr;
    return e;
  endfunction

  // check the current cycle at the falling edge, then move to the next cycle
  task automatic sc(input string nm, input logic [7:0] stb, input int beat, input bit busy,
                    input bit ill = 1'b0, input bit berr = 1'b0);
    @(negedge clk);
    cmp(nm, get_obs(), mk(stb, beat, busy, ill, berr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; go = 1'b0; zero = 1'b0; mem_rdy = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model: queue of micro-steps per instruction ----------------
  int    m_mode, m_wait, m_fb, m_wm;
  bit    m_ill, m_berr;
  step_t m_q[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_wait = 0; m_ill = 1'b0; m_berr = 1'b0; m_q.delete();
  endtask

  task automatic start_instr();
    m_mode = M_ACT;
    m_q.delete();
    for (int b = 0; b < m_fb; b++) m_q.push_back('{K_FETCH, b});
    m_q.push_back('{K_DEC, 0});
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    o.ill = m_ill; o.berr = m_berr;
    if (m_mode == M_HALT) begin
      o.stb = B_HALT;
    end else if (m_mode == M_ACT) begin
      o.busy = 1'b1;
      case (m_q[0].kind)
        K_FETCH: begin o.stb = mem_rdy ? B_FI : B_F; o.beat = 2'(m_q[0].beat); end
        K_RD:    o.stb = B_RD;
        K_ACC:   o.stb = B_RD | B_ACC;
        K_WR:    o.stb = B_WR | B_DEN;
        K_HOLD:  o.stb = B_DEN;
        K_JMP:   o.stb = B_LPC;
        K_SKIP:  o.stb = B_INC;
        default: o.stb = '0;
      endcase
    end
    return o;
  endfunction

  task automatic model_step();
    step_t s;
    int    opc;
    m_ill = 1'b0; m_berr = 1'b0;
    if (m_mode == M_IDLE) begin
      if (run) start_instr();
    end else if (m_mode == M_HALT) begin
      if (go) start_instr();
      else if (!run) m_mode = M_IDLE;
    end else begin
      s = m_q[0];
      if (s.kind == K_FETCH || s.kind == K_RD || s.kind == K_WR) begin
        if (mem_rdy) begin
          void'(m_q.pop_front()); m_wait = 0;
        end else if (m_wait == m_wm) begin
          m_berr = 1'b1; m_mode = M_HALT; m_q.delete(); m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        void'(m_q.pop_front());
        if (s.kind == K_DEC) begin
          opc = (sel == 0) ? int'(opcode[2:0]) : int'(opcode);
          if (opc > 7) m_ill = 1'b1;
          else if (opc == 0) m_mode = M_HALT;
          else if (opc == 1) begin
            if (zero) for (int b = 0; b < m_fb; b++) m_q.push_back('{K_SKIP, b});
          end else if (opc <= 5) begin
            m_q.push_back('{K_RD, 0}); m_q.push_back('{K_ACC, 0});
          end else if (opc == 6) begin
            m_q.push_back('{K_WR, 0}); m_q.push_back('{K_HOLD, 0});
          end else begin
            m_q.push_back('{K_JMP, 0});
          end
        end
      end
      if (m_mode == M_ACT && m_q.size() == 0) begin
        if (run) start_instr();
        else m_mode = M_IDLE;
      end
    end
  endtask

  function automatic vec_t mkv(input bit r, input bit rdy, input logic [2:0] opc,
                               input logic [7:0] stb, input int beat, input bit busy);
    vec_t v;
    v.run = r; v.rdy = rdy; v.opc = {1'b0, opc}; v.stb = stb; v.beat = beat; v.busy = busy;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[20];
    // LDA, then STO with three wait states, then JMP with run dropped mid-fetch (default params)
    tv[0]  = mkv(1, 1, OPC_LDA, 8'h00,         0, 0);
    tv[1]  = mkv(1, 1, OPC_LDA, B_FI,          0, 1);
    tv[2]  = mkv(1, 1, OPC_LDA, B_FI,          1, 1);
    tv[3]  = mkv(1, 1, OPC_LDA, 8'h00,         0, 1);
    tv[4]  = mkv(1, 1, OPC_LDA, B_RD,          0, 1);
    tv[5]  = mkv(1, 1, OPC_LDA, B_RD | B_ACC,  0, 1);
    tv[6]  = mkv(1, 1, OPC_STO, B_FI,          0, 1);
    tv[7]  = mkv(1, 1, OPC_STO, B_FI,          1, 1);
    tv[8]  = mkv(1, 0, OPC_STO, 8'h00,         0, 1);
    tv[9]  = mkv(1, 0, OPC_STO, B_WR | B_DEN,  0, 1);
    tv[10] = mkv(1, 0, OPC_STO, B_WR | B_DEN,  0, 1);
    tv[11] = mkv(1, 0, OPC_STO, B_WR | B_DEN,  0, 1);
    tv[12] = mkv(1, 1, OPC_STO, B_WR | B_DEN,  0, 1);
    tv[13] = mkv(1, 1, OPC_STO, B_DEN,         0, 1);
    tv[14] = mkv(0, 1, OPC_JMP, B_FI,          0, 1);
    tv[15] = mkv(0, 1, OPC_JMP, B_FI,          1, 1);
    tv[16] = mkv(0, 1, OPC_JMP, 8'h00,         0, 1);
    tv[17] = mkv(0, 1, OPC_JMP, B_LPC,         0, 1);
    tv[18] = mkv(0, 1, OPC_JMP, 8'h00,         0, 0);
    tv[19] = mkv(0, 1, OPC_JMP, 8'h00,         0, 0);

    sel = 0;
    @(negedge clk);
    cmp("reset_state", get_obs(), '0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run = tv[i].run; mem_rdy = tv[i].rdy; opcode = tv[i].opc;
      sc($sformatf("table[%0d]", i), tv[i].stb, tv[i].beat, tv[i].busy);
    end

    // SKZ with zero=1 then zero=0, three fetch beats
    sel = 1;
    do_reset();
    run = 1; mem_rdy = 1; opcode = 4'(OPC_SKZ); zero = 1;
    sc("skz_idle", 8'h00, 0, 0);
    for (int b = 0; b < 3; b++) sc("skz_fetch", B_FI, b, 1);
    sc("skz_decode", 8'h00, 0, 1);
    for (int b = 0; b < 3; b++) sc("skz_skip", B_INC, 0, 1);
    zero = 0;
    for (int b = 0; b < 3; b++) sc("skz0_fetch", B_FI, b, 1);
    sc("skz0_decode", 8'h00, 0, 1);
    sc("skz0_next", B_FI, 0, 1);

    // HLT: hold, resume on go, then park on run=0
    do_reset();
    run = 1; mem_rdy = 1; opcode = 4'(OPC_HLT);
    sc("hlt_idle", 8'h00, 0, 0);
    for (int b = 0; b < 3; b++) sc("hlt_fetch", B_FI, b, 1);
    sc("hlt_decode", 8'h00, 0, 1);
    for (int i = 0; i < 20; i++) sc("hlt_hold", B_HALT, 0, 0);
    go = 1;
    sc("hlt_go_cycle", B_HALT, 0, 0);
    go = 0;
    for (int b = 0; b < 3; b++) sc("hlt_go_fetch", B_FI, b, 1);
    sc("hlt2_decode", 8'h00, 0, 1);
    sc("hlt2_halt", B_HALT, 0, 0);
    run = 0;
    sc("hlt_run_low", B_HALT, 0, 0);
    sc("hlt_to_idle", 8'h00, 0, 0);

    // bus timeout with WAIT_MAX=4, then a rescue on the deciding cycle
    do_reset();
    run = 1; mem_rdy = 0; opcode = 4'(OPC_LDA);
    sc("to_idle", 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) sc("to_wait", B_F, 0, 1);
    sc("to_bus_err", B_HALT, 0, 0, 1'b0, 1'b1);
    sc("to_err_once", B_HALT, 0, 0);
    do_reset();
    run = 1; mem_rdy = 0;
    sc("rescue_idle", 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) sc("rescue_wait", B_F, 0, 1);
    mem_rdy = 1;
    sc("rescue_beat", B_FI, 0, 1);
    sc("rescue_no_err", B_FI, 1, 1);

    // illegal opcode with run dropped, then async reset in OPRD
    do_reset();
    run = 1; mem_rdy = 1; opcode = 4'b1010;
    sc("ill_idle", 8'h00, 0, 0);
    sc("ill_fetch0", B_FI, 0, 1);
    sc("ill_fetch1", B_FI, 1, 1);
    run = 0;
    sc("ill_fetch2", B_FI, 2, 1);
    sc("ill_decode", 8'h00, 0, 1);
    sc("ill_pulse", 8'h00, 0, 0, 1'b1);
    run = 1; opcode = 4'(OPC_LDA);
    sc("ill_once", 8'h00, 0, 0);
    for (int b = 0; b < 3; b++) sc("lda_fetch", B_FI, b, 1);
    sc("lda_decode", 8'h00, 0, 1);
    mem_rdy = 0;
    @(negedge clk);
    cmp("oprd_wait", get_obs(), mk(B_RD, 0, 1, 0, 0));
    #2 rst = 1'b1;
    #1 cmp("async_rst", get_obs(), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_rdy = 1;
    sc("rst_idle", 8'h00, 0, 0);
    sc("rst_refetch", B_FI, 0, 1);

    // randomized runs against the model, one per parameter set
    for (int p = 0; p < 2; p++) begin
      sel = p;
      m_fb = (p == 0) ? 2 : 3;
      m_wm = (p == 0) ? 15 : 4;
      do_reset();
      model_reset();
      for (int k = 0; k < 1500; k++) begin
        run     = ($urandom_range(0, 9) != 0);
        go      = ($urandom_range(0, 7) == 0);
        zero    = 1'($urandom_range(0, 1));
        mem_rdy = ((k % 200) < 40) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
        opcode  = 4'($urandom_range(0, 15));
        @(negedge clk);
        cmp("rand", get_obs(), model_out());
        @(posedge clk);
        model_step();
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctl_sequencer.md
Name: ctl_sequencer

Overview:
- Parametrised instruction-control sequencer for the RISC CPU core, successor to the fixed 8-slot control FSM.
- Fetches an instruction in FETCH_BEATS memory beats and decodes the opcode.
- Issues the control strobes to the PC, accumulator, IR, memory and data-bus driver.
- Uses a variable-length state sequence with a mem_rdy wait-state handshake, a bus timeout, and a halt/resume path.

Parameters:
- OPC_W, 3: opcode width; only the low 3 bits are decoded; nonzero upper bits mean an illegal opcode.
- FETCH_BEATS, 2: memory beats per instruction fetch, also the number of PC increments on a skip; must be at least 1.
- WAIT_MAX, 15: maximum cycles mem_rdy may stay low in a memory state before a bus error; must be at least 1.
- BEAT_W, max(1,clog2(FETCH_BEATS)): width of ir_beat (derived).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- run  in  1  1 = execute; 0 = park in IDLE at the next instruction boundary
- go  in  1  resume pulse; leaves HALT
- zero  in  1  accumulator-zero flag
- opcode  in  OPC_W  opcode field from the IR, stable from DECODE onward
- mem_rdy  in  1  memory completes the current rd/wr beat this cycle
- inc_pc, load_acc, load_pc, rd, wr, load_ir, halt, data_ctl_ena  out  1 each  control strobes
- ir_beat  out  BEAT_W  IR byte-lane select during fetch
- illegal  out  1  one-cycle pulse on an undecodable opcode
- bus_err  out  1  one-cycle pulse on a mem_rdy timeout
- busy  out  1  1 in every state except IDLE and HALT

Behaviour:
- Reset (async): state IDLE, beat_cnt 0, wait_cnt 0, all outputs 0.
- Output decoding: all outputs decode from registered state and counters.
  - Only Mealy terms: inc_pc in FETCH = mem_rdy; wr stays Moore.
  - illegal and bus_err are registered pulses.
- "next" means FETCH with beat_cnt=0 if run=1, otherwise IDLE.
- Opcode values: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- IDLE: no strobes; run=1 -> FETCH.
- FETCH: rd=1, load_ir=1, ir_beat=beat_cnt.
  - The IR captures on load_ir&mem_rdy.
  - On mem_rdy: inc_pc=1 and beat_cnt++.
  - On mem_rdy at the last beat: beat_cnt=0 -> DECODE.
  - Without mem_rdy: hold.
- DECODE (1 cycle, no strobes):
  - HLT -> HALT
  - SKZ with zero=1 -> SKIP; SKZ with zero=0 -> next
  - ADD/AND/XOR/LDA -> OPRD
  - STO -> STORE
  - JMP -> JUMP
  - upper opcode bits nonzero -> illegal=1 for 1 cycle, then next (treated as NOP)
- OPRD: rd=1; mem_rdy -> ACC.
- ACC (1 cycle): rd=1, load_acc=1 -> next.
- STORE: wr=1, data_ctl_ena=1; mem_rdy -> STHOLD.
- STHOLD (1 cycle): data_ctl_ena=1, wr=0 (data hold) -> next.
- JUMP (1 cycle): load_pc=1 -> next.
- SKIP: inc_pc=1 for exactly FETCH_BEATS cycles (beat_cnt counts) -> next.
- HALT: halt=1.
  - go=1 -> FETCH, and this wins over run.
  - go=0 with run=0 -> IDLE, with halt dropping.
  - Otherwise hold.
- Timeout in FETCH, OPRD or STORE:
  - wait_cnt increments each cycle mem_rdy=0 and clears on state change.
  - When wait_cnt reaches WAIT_MAX with mem_rdy=0: bus_err=1 for 1 cycle, -> HALT, strobes drop.
  - mem_rdy=1 in the same cycle wins over the timeout.
- run=0 mid-instruction: the instruction completes; the FSM then goes to IDLE.
- rst mid-instruction: immediate IDLE; in-flight rd/wr abandoned.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package/include ctl_defs:
  - opcode constants HLT..JMP
  - state encoding localparams (IDLE, FETCH, DECODE, OPRD, ACC, STORE, STHOLD, JUMP, SKIP, HALT)
  - strobe bit-vector indices, shared by the datapath and the bench
- One sub-module: ctl_wait_timer, the WAIT_MAX wait counter.
  - Inputs: clear, mem_rdy.
  - Output: timeout.
- The FSM lives in ctl_sequencer.

Test Plan:
1. Default params, run=1, mem_rdy=1, opcode=LDA: FETCH 2 cycles (ir_beat 0,1, inc_pc both), DECODE, OPRD, ACC (load_acc) -> back in FETCH on cycle 6 after reset release.
2. opcode=STO, mem_rdy low 3 cycles in STORE: wr=1 and data_ctl_ena=1 held 4 cycles, then STHOLD with data_ctl_ena=1, wr=0, then FETCH; no bus_err.
3. SKZ with zero=1, FETCH_BEATS=3: 3 fetch beats, DECODE, SKIP with inc_pc high exactly 3 cycles; repeat with zero=0: no SKIP, DECODE -> FETCH.
4. opcode=HLT: halt=1 persists 20 cycles with busy=0; go pulse -> FETCH next cycle with halt=0; separately run=0 in HALT -> IDLE.
5. WAIT_MAX=4, mem_rdy held 0 in FETCH: bus_err pulses once on the 5th cycle, then HALT with rd=0; mem_rdy=1 exactly on that cycle gives no error.
6. OPC_W=4, opcode=4'b1010: illegal pulses once after DECODE, no strobes beyond the fetch; rst asserted mid-OPRD drops all outputs asynchronously to 0 and state returns to IDLE.
